// File: rtl/aleatorio_pkg.sv
// ---------------------------------------------------------------------------
// aleatorio_pkg
// Shared types and constants for the random value generator that feeds the
// game initializer.
//   estado_gen_t : FSM states of generador_aleatorio
//   SEED_DEF     : reset seed, also used in place of an all-zero seed
//   TAPS_DEF     : Galois feedback mask for x^16+x^14+x^13+x^11+1
// ---------------------------------------------------------------------------
package aleatorio_pkg;

  typedef enum logic {
    REPOSO   = 1'b0,
    MUESTREO = 1'b1
  } estado_gen_t;

  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [15:0] TAPS_DEF = 16'hB400;

endpackage : aleatorio_pkg

// File: rtl/lfsr_galois.sv
// ---------------------------------------------------------------------------
// lfsr_galois
// Free-running Galois LFSR with a synchronous seed load that takes priority
// over stepping. A zero seed is replaced by SEED so the register can never
// lock up in the all-zero state.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset (loads SEED)
//   cargar     in   load dato_carga this edge instead of stepping
//   dato_carga in   seed value to load
//   estado     out  current LFSR register value
// ---------------------------------------------------------------------------
module lfsr_galois
  import aleatorio_pkg::*;
#(
  parameter int          W    = 16,
  parameter logic [W-1:0] SEED = SEED_DEF,
  parameter logic [W-1:0] TAPS = TAPS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cargar,
  input  logic [W-1:0] dato_carga,
  output logic [W-1:0] estado
);

  logic [W-1:0] estado_q;
  logic [W-1:0] estado_d;

  // Next value: a load wins over the step; shifting out a 1 applies the taps.
  always_comb begin
    estado_d = estado_q >> 1;
    if (estado_q[0]) begin
      estado_d = (estado_q >> 1) ^ TAPS;
    end
    if (cargar) begin
      estado_d = (dato_carga == '0) ? SEED : dato_carga;
    end
  end

  // LFSR register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= SEED;
    end else begin
      estado_q <= estado_d;
    end
  end

  assign estado = estado_q;

endmodule : lfsr_galois

// File: rtl/generador_aleatorio.sv
// ---------------------------------------------------------------------------
// generador_aleatorio
// Producer of valor_aleatorio for the game initializer. A one-cycle request
// in REPOSO starts sampling; each MUESTREO cycle takes the low WIDTH bits of
// the LFSR as a candidate and accepts it only if it is <= MAX_VAL (rejection
// sampling). An accepted value is registered and announced with a one-cycle
// valido strobe.
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   semilla_en      in   load semilla into the LFSR this edge
//   semilla         in   seed value (zero is replaced by SEED)
//   solicitar       in   request pulse, only honoured in REPOSO
//   valor_aleatorio out  last accepted value, held until the next one
//   valido          out  one-cycle strobe after an acceptance
//   ocupado         out  high while a request is being served
// ---------------------------------------------------------------------------
module generador_aleatorio
  import aleatorio_pkg::*;
#(
  parameter int                WIDTH   = 4,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = SEED_DEF,
  parameter logic [LFSR_W-1:0] TAPS    = TAPS_DEF,
  parameter int                MAX_VAL = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              semilla_en,
  input  logic [LFSR_W-1:0] semilla,
  input  logic              solicitar,
  output logic [WIDTH-1:0]  valor_aleatorio,
  output logic              valido,
  output logic              ocupado
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  estado_gen_t      estado_q;
  estado_gen_t      estado_d;
  logic [WIDTH-1:0] valor_q;
  logic [WIDTH-1:0] valor_d;
  logic             valido_q;
  logic             valido_d;

  logic [LFSR_W-1:0] lfsrEstado;
  logic [WIDTH-1:0]  candidato;
  logic              unusedLfsrBits;

  lfsr_galois #(
    .W    (LFSR_W),
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .cargar     (semilla_en),
    .dato_carga (semilla),
    .estado     (lfsrEstado)
  );

  // The candidate is the current register value; the LFSR keeps stepping
  // underneath, so every rejected cycle tries a fresh value.
  assign candidato      = lfsrEstado[WIDTH-1:0];
  assign unusedLfsrBits = ^lfsrEstado[LFSR_W-1:WIDTH];

  // Next-state and output logic. valido_d defaults low so the strobe lasts
  // exactly the one cycle following an acceptance.
  always_comb begin
    estado_d = estado_q;
    valor_d  = valor_q;
    valido_d = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (solicitar) begin
          estado_d = MUESTREO;
        end
      end
      MUESTREO: begin
        if (candidato <= MAX_W) begin
          valor_d  = candidato;
          valido_d = 1'b1;
          estado_d = REPOSO;
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= REPOSO;
      valor_q  <= '0;
      valido_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      valor_q  <= valor_d;
      valido_q <= valido_d;
    end
  end

  assign valor_aleatorio = valor_q;
  assign valido          = valido_q;
  assign ocupado         = (estado_q != REPOSO);

endmodule : generador_aleatorio

// File: doc/generador_aleatorio.md
Name: generador_aleatorio

Overview:
- Producer end of the `valor_aleatorio` interface consumed by the game initializer.
- Runs a free-running 16-bit Galois LFSR and accepts one-cycle requests.
- Delivers a registered value in range [0, MAX_VAL] with a one-cycle `valido` strobe, using rejection sampling; the initializer takes bit 0 as the starting player.
- Seed can be reloaded at runtime, e.g. from a free-running counter sampled at a button press.

Parameters:
- WIDTH, 4, width of `valor_aleatorio`.
- LFSR_W, 16, LFSR register width (taps below are fixed for 16).
- SEED, 16'hACE1, reset seed and replacement for an all-zero seed.
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
- MAX_VAL, 15, largest accepted output; must be ≤ 2^WIDTH-1 and ≥ 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- semilla_en  in  1  load `semilla` into the LFSR this edge.
- semilla  in  LFSR_W  seed value.
- solicitar  in  1  request pulse; sampled only in REPOSO.
- valor_aleatorio  out  WIDTH  last accepted value; held until the next acceptance.
- valido  out  1  registered one-cycle strobe, high in the cycle after acceptance.
- ocupado  out  1  high whenever state ≠ REPOSO (state decode).

Behaviour:
- Reset (async, active-high): lfsr=SEED, state=REPOSO, valor_aleatorio=0, valido=0, ocupado=0.
- LFSR step, every edge not loading:
  - if lfsr[0]=1: lfsr = (lfsr>>1) ^ TAPS
  - else: lfsr = lfsr>>1
- Seed load:
  - `semilla_en` has priority over stepping: lfsr = (semilla==0) ? SEED : semilla.
  - The all-zero state is therefore unreachable.
  - A load during MUESTREO is legal; sampling continues on the new value next cycle, and the FSM is unaffected.
- FSM states: REPOSO, MUESTREO.
  - REPOSO: if solicitar=1 → MUESTREO.
  - MUESTREO: candidate = lfsr[WIDTH-1:0] (current register value).
    - If candidate ≤ MAX_VAL: valor_aleatorio ≤ candidate, valido ≤ 1, → REPOSO.
    - Else stay (reject).
  - valido is cleared on every other edge, so it is exactly one cycle wide.
- Latency: solicitar sampled at edge N; best-case acceptance at edge N+1; valido high during cycle N+1..N+2.
  - Each rejection adds one cycle.
  - The LFSR visits all 2^16-1 nonzero states, so a candidate ≤ MAX_VAL always appears; no timeout is needed.
- solicitar while ocupado=1: ignored; no queueing.
- solicitar held high: a new request starts on the edge after returning to REPOSO, so back-to-back strobes are separated by at least one cycle.
- Reset mid-MUESTREO: immediate return to reset values; no valido emitted.
- MAX_VAL=2^WIDTH-1: no rejections; fixed latency of one edge after the request edge.

Decomposition:
- Package `aleatorio_pkg`:
  - typedef `enum logic {REPOSO, MUESTREO}` estado_gen_t
  - localparams SEED_DEF=16'hACE1, TAPS_DEF=16'hB400
- Sub-module `lfsr_galois` (inputs clk, reset, cargar, dato_carga; output estado).
  - Contains the step and zero-guard logic.
  - Its reset value comes from a parameter.
- Top module: FSM, output registers, valido strobe.

Test Plan:
1. Default params. semilla=16'hACE1, semilla_en at edge E0; solicitar at edge E1 (lfsr→E270) → at E2 accept candidate 0: valor_aleatorio=0, valido=1 for exactly one cycle, ocupado high only between E1 and E2. bit0=0, so jugador_inicial=0 at the consumer.
2. MAX_VAL=5. semilla=16'h000F load at E0; solicitar at E1 (lfsr→B407) → E2 rejects 7 (lfsr→EE03); E3 accepts 3; valido after E3; valor_aleatorio=3. Total latency 2 edges after the request edge.
3. semilla=16'h0000 load → lfsr reads 16'hACE1. Then repeat scenario 1 timing → identical result, valor_aleatorio=0.
4. solicitar pulsed again during MUESTREO (scenario 2 at E2) → ignored; exactly one valido pulse; valor_aleatorio=3 held afterwards.
5. reset asserted asynchronously mid-MUESTREO (scenario 2 between E2 and E3) → valido=0, ocupado=0, valor_aleatorio=0 immediately, lfsr=ACE1; no strobe after release.
6. solicitar held high for 200 cycles, MAX_VAL=5 → every captured value ≤ 5; valido pulses never adjacent; bit0 takes both 0 and 1 at least once.
